fetch_sequencer: RTL and testbench

Instruction fetch and phase sequencer for the 8-bit MCU. It holds the PC and fetches each instruction from instruction memory over a req/ack handshake. It latches the instruction into an instruction register and slices it into the SM/OP/register/immediate fields. It then drives the phase counter `cnt_clk` that the downstream control unit decodes, and finally updates the PC from the control unit's `PC_Ctr` decision (increment or jump).

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch and execute-phase sequencer for the 8-bit MCU.
// Fetches one word over req/ack, freezes it in IR, steps cnt_clk, then updates the PC.
module fetch_sequencer #(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned SIZE_CNT   = 2,
    parameter int unsigned LAST_PHASE = 3
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    input  logic                pc_ctr,
    input  logic                halt,
    output logic [PC_W-1:0]     pc,
    output logic [1:0]          sm,
    output logic [3:0]          op,
    output logic [1:0]          rd,
    output logic [7:0]          imm,
    output logic [SIZE_CNT:0]   cnt_clk,
    output logic                instr_done,
    output logic                halted
);

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalted
    } state_e;

    localparam logic [SIZE_CNT:0] CntIdle = '1;
    localparam logic [SIZE_CNT:0] CntLast = (SIZE_CNT + 1)'(LAST_PHASE);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [SIZE_CNT:0]   cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [PC_W-1:0]     jump_tgt;
    logic                last_phase;

    // imm is zero-extended or truncated to the PC width.
    always_comb begin
        jump_tgt = '0;
        for (int i = 0; i < int'(PC_W) && i < 8; i++) begin
            jump_tgt[i] = ir_q[i];
        end
    end

    assign last_phase = (state_q == StExec) && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            StFetch: begin
                // An ack only counts while our request is actually out.
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    state_d = StExec;
                end else begin
                    req_d = 1'b1;
                end
            end
            StExec: begin
                if (cnt_q == CntLast) begin
                    pc_d  = pc_ctr ? pc_q + PC_W'(1) : jump_tgt;
                    cnt_d = CntIdle;
                    if (halt) begin
                        state_d = StHalted;
                        req_d   = 1'b0;
                    end else begin
                        state_d = StFetch;
                        req_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + (SIZE_CNT + 1)'(1);
                end
            end
            StHalted: begin
                if (!halt) begin
                    state_d = StFetch;
                    req_d   = 1'b1;
                end
            end
            default: begin
                state_d = StFetch;
                cnt_d   = CntIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= CntIdle;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign sm         = ir_q[15:14];
    assign op         = ir_q[13:10];
    assign rd         = ir_q[9:8];
    assign imm        = ir_q[7:0];
    assign cnt_clk    = cnt_q;
    assign instr_done = last_phase;
    assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-instruction transaction model with random waits,
// jumps, halts and noise on inputs that must be ignored.
module tb_fetch_sequencer;

    localparam int PC_W       = 8;
    localparam int SIZE_CNT   = 2;
    localparam int LAST_PHASE = 3;
    localparam int IDLE       = (1 << (SIZE_CNT + 1)) - 1;

    logic                clk;
    logic                rst;
    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_ack;
    logic [15:0]         imem_rdata;
    logic                pc_ctr;
    logic                halt;
    logic [PC_W-1:0]     pc;
    logic [1:0]          sm;
    logic [3:0]          op;
    logic [1:0]          rd;
    logic [7:0]          imm;
    logic [SIZE_CNT:0]   cnt_clk;
    logic                instr_done;
    logic                halted;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: address of the next fetch and the last accepted instruction word.
    logic [7:0]  mpc;
    logic [15:0] mir;

    fetch_sequencer #(
        .PC_W      (PC_W),
        .SIZE_CNT  (SIZE_CNT),
        .LAST_PHASE(LAST_PHASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .pc_ctr    (pc_ctr),
        .halt      (halt),
        .pc        (pc),
        .sm        (sm),
        .op        (op),
        .rd        (rd),
        .imm       (imm),
        .cnt_clk   (cnt_clk),
        .instr_done(instr_done),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_ir(input string tag);
        check(tag, 32'({sm, op, rd, imm}), 32'(mir));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        halt     = 1'b0;
        #1;
        check("rst_addr", 32'(imem_addr), 32'(0));
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_cnt", 32'(cnt_clk), 32'(IDLE));
        check("rst_ir", 32'({sm, op, rd, imm}), 32'(0));
        check("rst_req", 32'(imem_req), 32'(0));
        check("rst_done", 32'(instr_done), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        // Stray ack while no request is outstanding.
        imem_ack   = 1'b1;
        imem_rdata = 16'($urandom);
        check("post_rst_req", 32'(imem_req), 32'(0));
        @(negedge clk);
        imem_ack = 1'b0;
        mpc      = 8'h00;
        mir      = 16'h0000;
        check_ir("stray_ack_ir");
    endtask

    // One instruction: fetch with `waits` wait cycles, full execute, optional halt period.
    task automatic do_instr(input logic [15:0] word, input int waits, input bit ctr,
                            input bit hlt, input int hold);
        for (int w = 0; w <= waits; w++) begin
            check("f_req", 32'(imem_req), 32'(1));
            check("f_addr", 32'(imem_addr), 32'(mpc));
            check("f_pc", 32'(pc), 32'(mpc));
            check("f_cnt", 32'(cnt_clk), 32'(IDLE));
            check("f_done", 32'(instr_done), 32'(0));
            check("f_halted", 32'(halted), 32'(0));
            check_ir("f_ir");
            imem_ack   = (w == waits);
            imem_rdata = (w == waits) ? word : 16'($urandom);
            pc_ctr     = 1'($urandom);
            halt       = 1'($urandom);
            @(negedge clk);
        end
        mir = word;
        for (int p = 0; p <= LAST_PHASE; p++) begin
            check("x_req", 32'(imem_req), 32'(0));
            check("x_cnt", 32'(cnt_clk), 32'(p));
            check("x_done", 32'(instr_done), 32'(p == LAST_PHASE));
            check("x_halted", 32'(halted), 32'(0));
            check("x_addr", 32'(imem_addr), 32'(mpc));
            check_ir("x_ir");
            imem_ack   = 1'($urandom);
            imem_rdata = 16'($urandom);
            if (p == LAST_PHASE) begin
                pc_ctr = ctr;
                halt   = hlt;
            end else begin
                pc_ctr = 1'($urandom);
                halt   = hlt ? (p >= 1) : 1'($urandom);
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        mpc      = ctr ? mpc + 8'h01 : word[7:0];
        if (hlt) begin
            for (int h = 0; h <= hold; h++) begin
                check("h_halted", 32'(halted), 32'(1));
                check("h_req", 32'(imem_req), 32'(0));
                check("h_cnt", 32'(cnt_clk), 32'(IDLE));
                check("h_pc", 32'(pc), 32'(mpc));
                check("h_done", 32'(instr_done), 32'(0));
                check_ir("h_ir");
                halt     = (h < hold);
                pc_ctr   = 1'($urandom);
                imem_ack = 1'($urandom);
                @(negedge clk);
            end
            imem_ack = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        pc_ctr     = 1'b0;
        halt       = 1'b0;
        mpc        = 8'h00;
        mir        = 16'h0000;

        do_reset();
        do_instr(16'h4000, 0, 1'b1, 1'b0, 0);
        do_instr(16'h4401, 0, 1'b1, 1'b0, 0);
        do_instr(16'h4802, 0, 1'b1, 1'b0, 0);
        do_instr(16'h4C03, 3, 1'b1, 1'b0, 0);
        do_instr(16'hC0A5, 0, 1'b0, 1'b0, 0);
        check("jump_addr", 32'(imem_addr), 32'h0000_00A5);
        do_instr(16'h80FF, 1, 1'b0, 1'b0, 0);
        do_instr(16'h1234, 0, 1'b1, 1'b0, 0);
        check("wrap_addr", 32'(imem_addr), 32'h0000_0000);
        do_instr(16'h5511, 0, 1'b1, 1'b1, 5);

        for (int i = 0; i < 150; i++) begin
            do_instr(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                     ($urandom_range(0, 7) == 0), int'($urandom_range(1, 4)));
        end

        // Abort an instruction in phase 2, then confirm a clean restart from pc 0.
        check("ab_req", 32'(imem_req), 32'(1));
        imem_ack   = 1'b1;
        imem_rdata = 16'hE7C3;
        @(negedge clk);
        imem_ack = 1'b0;
        mir      = 16'hE7C3;
        for (int p = 0; p <= 2; p++) begin
            check("ab_cnt", 32'(cnt_clk), 32'(p));
            check_ir("ab_ir");
            if (p < 2) @(negedge clk);
        end
        #2;
        do_reset();
        do_instr(16'h6B10, 2, 1'b1, 1'b0, 0);
        check("restart_addr", 32'(imem_addr), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
